// File: rtl/irq_pkg.sv
// irq_pkg: shared definitions for the interrupt controller.
//   irq_state_e : controller FSM states (IDLE, REQ, SERVICE)
//   MAX_SRC     : largest supported number of interrupt sources
package irq_pkg;

    localparam int MAX_SRC = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational fixed-priority encoder, lowest index wins.
// Ports:
//   req   in  N  request vector
//   valid out 1  at least one request bit set
//   idx   out W  index of the lowest set request bit (0 when none)
module irq_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [W-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last to write.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// irq_controller: edge-triggered interrupt controller with mask register,
// fixed priority (lowest index highest) and an IDLE/REQ/SERVICE handshake
// with the CPU (ack moves the request into service, eoi ends it).
// Optional build macro IRQ_SYNC_EN: adds a 2-flop synchronizer per irq_in
// bit ahead of edge detection (edge-to-cpu_irq latency 4 instead of 2).
// Ports:
//   clk        in   clock, all state on posedge
//   rst        in   asynchronous active-high reset
//   irq_in     in   NUM_SRC  interrupt sources, rising edge = request
//   mask_we    in   mask register write strobe
//   mask_wdata in   NUM_SRC  mask write data, 1 = masked
//   cpu_ack    in   CPU acknowledge pulse
//   cpu_eoi    in   CPU end-of-interrupt pulse
//   cpu_irq    out  interrupt request to the CPU
//   irq_vec    out  VEC_W   index of source requested / in service
//   pending    out  NUM_SRC pending register
//   mask       out  NUM_SRC mask register
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 4,
    localparam int VEC_W  = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               cpu_ack,
    input  logic               cpu_eoi,
    output logic               cpu_irq,
    output logic [VEC_W-1:0]   irq_vec,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask
);

    logic [NUM_SRC-1:0] irq_src;

`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q, sync1_d;
    logic [NUM_SRC-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = irq_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign irq_src = sync2_q;
`else
    assign irq_src = irq_in;
`endif

    irq_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] prev_q, prev_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [VEC_W-1:0]   vec_q, vec_d;

    logic [NUM_SRC-1:0] edge_det;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] sel_req;
    logic               sel_valid;
    logic [VEC_W-1:0]   sel_idx;
    logic               ack_fire;

    assign sel_req = pending_q & ~mask_q;

    irq_prio_enc #(
        .N (NUM_SRC),
        .W (VEC_W)
    ) u_prio_enc (
        .req   (sel_req),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        ack_fire = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    vec_d   = sel_idx;
                    state_d = REQ;
                end
            end
            REQ: begin
                // A mask on the requested source withdraws the request;
                // it takes precedence over an ack in the same cycle.
                if (mask_q[vec_q]) begin
                    state_d = IDLE;
                end else if (cpu_ack) begin
                    ack_fire = 1'b1;
                    state_d  = SERVICE;
                end
            end
            SERVICE: begin
                if (cpu_eoi) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        edge_det = irq_src & ~prev_q;
        prev_d   = irq_src;
        mask_d   = mask_we ? mask_wdata : mask_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            ack_clr[i] = ack_fire && (vec_q == VEC_W'(i));
        end
        // Set after clear: a new edge on the acked bit keeps it pending.
        pending_d = (pending_q & ~ack_clr) | edge_det;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            vec_q     <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            vec_q     <= vec_d;
        end
    end

    // Derived from the state register so an asynchronous reset drops the
    // request immediately, and gated by the mask so a masking write
    // withdraws it as soon as the mask register updates.
    assign cpu_irq = (state_q == REQ) && !mask_q[vec_q];
    assign irq_vec = vec_q;
    assign pending = pending_q;
    assign mask    = mask_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed-vector bench for irq_controller (NUM_SRC=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled at
// the same point, i.e. well away from the active edge.
module tb_irq_controller;

    logic       clk;
    logic       rst;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       cpu_ack;
    logic       cpu_eoi;
    logic       cpu_irq;
    logic [1:0] irq_vec;
    logic [3:0] pending;
    logic [3:0] mask;

    int tests_run;
    int tests_failed;

    irq_controller #(.NUM_SRC(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_eoi    (cpu_eoi),
        .cpu_irq    (cpu_irq),
        .irq_vec    (irq_vec),
        .pending    (pending),
        .mask       (mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_we    = 1'b1;
        mask_wdata = m;
        tick();
        mask_we    = 1'b0;
    endtask

    task automatic pulse_irq(input logic [3:0] v);
        irq_in = v;
        tick();
        irq_in = 4'b0000;
    endtask

    task automatic do_ack();
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
    endtask

    task automatic do_eoi();
        cpu_eoi = 1'b1;
        tick();
        cpu_eoi = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst        = 1'b1;
        irq_in     = 4'b0000;
        mask_we    = 1'b0;
        mask_wdata = 4'b0000;
        cpu_ack    = 1'b0;
        cpu_eoi    = 1'b0;

        tick();
        tick();
        check("reset_cpu_irq", 32'(cpu_irq), 32'd0);
        check("reset_vec",     32'(irq_vec), 32'd0);
        check("reset_pending", 32'(pending), 32'h0);
        check("reset_mask",    32'(mask),    32'hf);
        rst = 1'b0;

`ifdef IRQ_SYNC_EN
        // Synchronized build: edge-to-request latency is 4 cycles.
        write_mask(4'b0000);
        irq_in = 4'b0010;
        tick();
        tick();
        irq_in = 4'b0000;
        check("sync_t2_irq", 32'(cpu_irq), 32'd0);
        tick();
        check("sync_t3_pending", 32'(pending), 32'h2);
        check("sync_t3_irq", 32'(cpu_irq), 32'd0);
        tick();
        check("sync_t4_irq", 32'(cpu_irq), 32'd1);
        check("sync_t4_vec", 32'(irq_vec), 32'd1);
        do_ack();
        check("sync_ack_irq", 32'(cpu_irq), 32'd0);
        check("sync_ack_pending", 32'(pending), 32'h0);
`else
        // Single source: request 2 cycles after the edge, ack clears it.
        write_mask(4'b0000);
        check("mask_zero", 32'(mask), 32'h0);
        pulse_irq(4'b0100);
        check("s2_pending", 32'(pending), 32'h4);
        check("s2_irq_t1",  32'(cpu_irq), 32'd0);
        tick();
        check("s2_irq_t2",  32'(cpu_irq), 32'd1);
        check("s2_vec",     32'(irq_vec), 32'd2);
        do_ack();
        check("s2_ack_pending", 32'(pending), 32'h0);
        check("s2_ack_irq",     32'(cpu_irq), 32'd0);
        check("s2_service_vec", 32'(irq_vec), 32'd2);
        do_eoi();
        check("s2_eoi_irq", 32'(cpu_irq), 32'd0);

        // Two simultaneous sources: lower index served first.
        pulse_irq(4'b1010);
        check("dual_pending", 32'(pending), 32'ha);
        tick();
        check("dual_first_irq", 32'(cpu_irq), 32'd1);
        check("dual_first_vec", 32'(irq_vec), 32'd1);
        do_ack();
        check("dual_ack_pending", 32'(pending), 32'h8);
        do_eoi();
        tick();
        check("dual_second_irq", 32'(cpu_irq), 32'd1);
        check("dual_second_vec", 32'(irq_vec), 32'd3);
        do_ack();
        do_eoi();

        // Masked source still pends but does not request until unmasked.
        write_mask(4'b0001);
        pulse_irq(4'b0001);
        check("masked_pending", 32'(pending), 32'h1);
        tick();
        tick();
        check("masked_irq", 32'(cpu_irq), 32'd0);
        write_mask(4'b0000);
        check("unmask_irq_t1", 32'(cpu_irq), 32'd0);
        tick();
        check("unmask_irq", 32'(cpu_irq), 32'd1);
        check("unmask_vec", 32'(irq_vec), 32'd0);

        // In SERVICE: ack is ignored, the new edge only pends.
        do_ack();
        irq_in  = 4'b0001;
        cpu_ack = 1'b1;
        tick();
        irq_in  = 4'b0000;
        cpu_ack = 1'b0;
        check("svc_ack_ign_pending", 32'(pending), 32'h1);
        check("svc_ack_ign_irq",     32'(cpu_irq), 32'd0);
        do_eoi();
        tick();
        check("svc_rereq_irq", 32'(cpu_irq), 32'd1);
        check("svc_rereq_vec", 32'(irq_vec), 32'd0);

        // Edge on the acked bit in the ack cycle: set wins.
        irq_in  = 4'b0001;
        cpu_ack = 1'b1;
        tick();
        irq_in  = 4'b0000;
        cpu_ack = 1'b0;
        check("setwin_pending", 32'(pending), 32'h1);
        check("setwin_irq",     32'(cpu_irq), 32'd0);
        do_eoi();
        tick();
        check("setwin_rereq", 32'(cpu_irq), 32'd1);
        do_ack();
        check("setwin_clear", 32'(pending), 32'h0);
        do_eoi();

        // Masking the requested source in REQ withdraws it, pending kept.
        pulse_irq(4'b0010);
        tick();
        check("mreq_irq", 32'(cpu_irq), 32'd1);
        write_mask(4'b0010);
        tick();
        check("mreq_drop_irq",     32'(cpu_irq), 32'd0);
        check("mreq_keep_pending", 32'(pending), 32'h2);
        do_ack();
        check("idle_ack_ign", 32'(pending), 32'h2);
        write_mask(4'b0000);
        tick();
        check("mreq_rereq_vec", 32'(irq_vec), 32'd1);
        do_ack();
        check("mreq_ack_irq", 32'(cpu_irq), 32'd0);

        // Simultaneous mask write and edge both take effect.
        mask_we    = 1'b1;
        mask_wdata = 4'b0100;
        irq_in     = 4'b0100;
        tick();
        mask_we    = 1'b0;
        irq_in     = 4'b0000;
        check("simul_mask",    32'(mask),    32'h4);
        check("simul_pending", 32'(pending), 32'h4);
        do_eoi();
        tick();
        check("simul_masked_irq", 32'(cpu_irq), 32'd0);

        // Asynchronous reset in the middle of REQ.
        write_mask(4'b0000);
        tick();
        check("rst_pre_irq", 32'(cpu_irq), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_irq", 32'(cpu_irq), 32'd0);
        check("rst_pending",   32'(pending), 32'h0);
        check("rst_mask",      32'(mask),    32'hf);

        // Source high across reset release counts as an edge.
        irq_in = 4'b1000;
        tick();
        rst = 1'b0;
        tick();
        check("rel_edge_pending", 32'(pending), 32'h8);
        check("rel_masked_irq",   32'(cpu_irq), 32'd0);
        irq_in = 4'b0000;
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
